// File: rtl/string_packer.sv
// -----------------------------------------------------------------------------
// string_packer
//
// Width-up converter. It concatenates RATIO consecutive IN_W-bit input words
// into one OUT_W-bit output word. The first word of a group lands in the most
// significant slot, as in {a,b,c,d}. A flush request emits a partially filled
// word, left-justified, with the unused slots holding the pad word.
//
// Optional feature macro: STRING_PACKER_PAD_EN
//   defined     : pad word is 8'h20 (ASCII space), zero-extended to IN_W
//   not defined : pad word is all zeros
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   in_data is presented
//   in_ready   block accepts in_data this cycle (combinational)
//   in_data    input word, IN_W bits
//   flush      single-cycle request to emit the partial word
//   out_valid  out_data / out_count are valid (registered)
//   out_ready  consumer accepts out_data this cycle
//   out_data   packed word; first word in bits [OUT_W-1 -: IN_W] (registered)
//   out_count  number of real words in out_data, 1..RATIO (registered)
// -----------------------------------------------------------------------------
module string_packer #(
  parameter  int IN_W  = 8,
  parameter  int RATIO = 4,
  localparam int OUT_W = IN_W * RATIO,
  localparam int CW    = $clog2(RATIO + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CW-1:0]    out_count
);

`ifdef STRING_PACKER_PAD_EN
  localparam logic [IN_W-1:0] PAD_WORD = IN_W'(8'h20);
`else
  localparam logic [IN_W-1:0] PAD_WORD = '0;
`endif
  localparam logic [OUT_W-1:0] PAD_FILL = {RATIO{PAD_WORD}};
  localparam logic [CW-1:0]    FULL_CNT = CW'(RATIO);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,  // no words collected, nothing presented
    S_FILL  = 2'd1,  // 0 < count < RATIO, nothing presented
    S_HOLD  = 2'd2   // a packed word is presented on the output
  } state_t;

  state_t             state_q,      state_d;
  logic [OUT_W-1:0]   buf_q,        buf_d;        // group being collected
  logic [CW-1:0]      count_q,      count_d;      // words in buf_q
  logic               flush_pend_q, flush_pend_d; // flush seen while in HOLD
  logic [OUT_W-1:0]   out_data_q,   out_data_d;
  logic [CW-1:0]      out_count_q,  out_count_d;
  logic               out_valid_q,  out_valid_d;

  logic               accept;
  logic               handshake;
  logic [OUT_W-1:0]   buf_w;   // buf_q with this cycle's accepted word merged
  logic [CW-1:0]      cnt_w;   // count_q including this cycle's accept

  // A new group may start in the very cycle the held word is handed off.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  // Merge the accepted word into the slot selected by the current count.
  // Word k of a group goes to slot RATIO-1-k, i.e. the MSB end fills first.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every variable a
    // default first, so later statements see the updated value and no latch
    // is inferred on paths that leave a signal unassigned.
    buf_w = buf_q;
    for (int k = 0; k < RATIO; k++) begin
      if (accept && (count_q == CW'(k))) begin
        buf_w[(RATIO-k)*IN_W-1 -: IN_W] = in_data;
      end
    end
    cnt_w = count_q + {{(CW-1){1'b0}}, accept};
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    count_d      = count_q;
    flush_pend_d = flush_pend_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_valid_d  = out_valid_q;

    unique case (state_q)
      S_EMPTY: begin
        // A flush with nothing collected is ignored, even alongside an accept.
        if (accept) begin
          buf_d   = buf_w;
          count_d = cnt_w;
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        // Completing the group and flushing emit the same thing: the merged
        // buffer with its real word count. A flush arriving with the final
        // word is thereby consumed by the full-word emission.
        if ((accept && (cnt_w == FULL_CNT)) || flush || flush_pend_q) begin
          out_data_d   = buf_w;
          out_count_d  = cnt_w;
          out_valid_d  = 1'b1;
          buf_d        = PAD_FILL;
          count_d      = '0;
          flush_pend_d = 1'b0;
          state_d      = S_HOLD;
        end else begin
          buf_d   = buf_w;
          count_d = cnt_w;
        end
      end

      S_HOLD: begin
        // Remember a flush seen while the output is stalled; it applies to
        // the group that starts in the handoff cycle, if any.
        flush_pend_d = flush_pend_q || flush;
        if (handshake) begin
          out_valid_d = 1'b0;
          if (accept) begin
            buf_d   = buf_w;
            count_d = cnt_w;
            state_d = S_FILL;
          end else begin
            flush_pend_d = 1'b0;
            state_d      = S_EMPTY;
          end
        end
      end

      default: begin
        state_d      = S_EMPTY;
        buf_d        = PAD_FILL;
        count_d      = '0;
        flush_pend_d = 1'b0;
        out_valid_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update together
  // at the edge regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the slot buffer and output word are reset to the pad pattern
      // because unwritten slots must read as pad once a partial word is
      // flushed; this is a handful of flops, not a RAM, so resetting is cheap.
      state_q      <= S_EMPTY;
      buf_q        <= PAD_FILL;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= PAD_FILL;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_string_packer.sv
// -----------------------------------------------------------------------------
// tb_string_packer
//
// Self-checking bench for string_packer (IN_W=8, RATIO=4). A transaction-level
// reference model (a queue of collected words plus hold/pending flags) predicts
// each packed output and pushes it into a scoreboard queue; an independent
// monitor pops and compares whenever the DUT presents out_valid.
// -----------------------------------------------------------------------------
module tb_string_packer;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO + 1);

`ifdef STRING_PACKER_PAD_EN
  localparam logic [IN_W-1:0] PAD = 8'h20;
`else
  localparam logic [IN_W-1:0] PAD = 8'h00;
`endif
  localparam logic [OUT_W-1:0] PAD_FILL = {RATIO{PAD}};

  typedef struct {
    logic [OUT_W-1:0] data;
    int               cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CW-1:0]    out_count;

  int n_vec = 0;
  int n_err = 0;

  exp_t            exp_q[$];
  logic [IN_W-1:0] m_grp[$];
  bit              m_hold = 0;
  bit              m_pend = 0;

  string_packer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Left-justified concatenation of the collected words, pad in unused slots.
  function automatic logic [OUT_W-1:0] pack(input logic [IN_W-1:0] w[$]);
    logic [OUT_W-1:0] r = '0;
    for (int k = 0; k < RATIO; k++) begin
      r = {r[OUT_W-IN_W-1:0], (k < w.size()) ? w[k] : PAD};
    end
    return r;
  endfunction

  // Advance the reference model across the upcoming clock edge.
  task automatic model_step(input bit v, input logic [IN_W-1:0] d, input bit f, input bit r);
    bit acc = v && (!m_hold || r);
    int nb  = m_grp.size();
    if (m_hold) begin
      if (f) m_pend = 1;
      if (r) begin
        m_hold = 0;
        if (acc) m_grp.push_back(d);
        else     m_pend = 0;
      end
    end else begin
      if (acc) m_grp.push_back(d);
      if (m_grp.size() == RATIO || (f && nb > 0) || m_pend) begin
        exp_q.push_back('{data: pack(m_grp), cnt: m_grp.size()});
        m_grp.delete();
        m_pend = 0;
        m_hold = 1;
      end
    end
  endtask

  // One clock cycle of stimulus; handshake signals are checked against the model.
  task automatic cycle(input bit v, input logic [IN_W-1:0] d, input bit f, input bit r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    #1;
    check("in_ready", 64'(in_ready), 64'(!m_hold || r));
    check("out_valid", 64'(out_valid), 64'(m_hold));
    model_step(v, d, f, r);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
  task automatic reset_midcycle();
    @(posedge clk);
    #3;
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_data", 64'(out_data), 64'(PAD_FILL));
    check("rst_in_ready", 64'(in_ready), 64'd1);
    m_grp.delete();
    m_hold = 0;
    m_pend = 0;
    exp_q.delete();
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: peek while stalled (stability), pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          check("sb_out_data", 64'(out_data), 64'(exp_q[0].data));
          check("sb_out_count", 64'(out_count), 64'(exp_q[0].cnt));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] this_s [4] = '{8'h74, 8'h68, 8'h69, 8'h73};
    logic [7:0] abcd_s [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
    logic [7:0] xyz_s  [4] = '{8'h58, 8'h59, 8'h5A, 8'h3A};

    idle_inputs();
    reset = 1'b1;
    #12;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_count", 64'(out_count), 64'd0);
    check("reset_out_data", 64'(out_data), 64'(PAD_FILL));
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // "this" with out_ready held high.
    for (int i = 0; i < 4; i++) cycle(1, this_s[i], 0, 1);
    cycle(0, 8'h00, 0, 1);
    check("this_data", 64'(out_data), 64'h74686973);
    check("this_count", 64'(out_count), 64'd4);

    // "is" then flush: left-justified partial word.
    cycle(1, 8'h69, 0, 1);
    cycle(1, 8'h73, 0, 1);
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 0, 1);
    check("is_data", 64'(out_data), 64'({8'h69, 8'h73, PAD, PAD}));
    check("is_count", 64'(out_count), 64'd2);

    // "abcdabcdabcd" streamed back to back.
    for (int i = 0; i < 12; i++) cycle(1, abcd_s[i % 4], 0, 1);
    cycle(0, 8'h00, 0, 1);

    // Stall with out_ready low, flush while held, then handoff with 0x41.
    cycle(1, 8'h77, 0, 0);
    cycle(1, 8'h78, 0, 0);
    cycle(1, 8'h79, 0, 0);
    cycle(1, 8'h7A, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'h55, 0, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(1, 8'h41, 0, 1);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 0);
    check("pend_data", 64'(out_data), 64'({8'h41, PAD, PAD, PAD}));
    check("pend_count", 64'(out_count), 64'd1);
    cycle(0, 8'h00, 0, 1);

    // Flush with nothing collected, then flush alongside the fourth word.
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1);
    cycle(1, 8'h31, 0, 1);
    cycle(1, 8'h32, 0, 1);
    cycle(1, 8'h33, 0, 1);
    cycle(1, 8'h34, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 1);

    // Reset after two words, then "XYZ:".
    cycle(1, 8'h11, 0, 1);
    cycle(1, 8'h22, 0, 1);
    reset_midcycle();
    for (int i = 0; i < 4; i++) cycle(1, xyz_s[i], 0, 1);
    cycle(0, 8'h00, 0, 1);
    check("xyz_data", 64'(out_data), 64'h58595A3A);
    check("xyz_count", 64'(out_count), 64'd4);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0);
    end

    // Drain: flush any partial group and let every held word go.
    cycle(0, 8'h00, 1, 1);
    for (int i = 0; i < 20; i++) cycle(0, 8'h00, 0, 1);
    @(negedge clk);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
